// File: rtl/ysyx_22050710_mem_stage.sv
// Memory-access pipeline stage: latches one EX instruction, issues at most one data-memory
// request, aligns/extends load data and hands the result to WB; also feeds the DS bypass.
module ysyx_22050710_mem_stage #(
    parameter int unsigned WORD_WD         = 64,
    parameter int unsigned GPR_ADDR_WD     = 5,
    parameter int unsigned CSR_ADDR_WD     = 12,
    parameter int unsigned ES_TO_MS_BUS_WD = 216,
    parameter int unsigned MS_TO_WS_BUS_WD = 147,
    parameter int unsigned BYPASS_BUS_WD   = 145
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] i_es_to_ms_bus,
    output logic                       o_ms_allowin,
    input  logic                       i_ws_allowin,
    output logic                       o_ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] o_ms_to_ws_bus,
    output logic                       o_dmem_req_valid,
    input  logic                       i_dmem_req_ready,
    output logic [WORD_WD-1:0]         o_dmem_addr,
    output logic                       o_dmem_wen,
    output logic [WORD_WD-1:0]         o_dmem_wdata,
    output logic [7:0]                 o_dmem_wmask,
    input  logic                       i_dmem_rsp_valid,
    input  logic [WORD_WD-1:0]         i_dmem_rdata,
    output logic [BYPASS_BUS_WD-1:0]   o_ms_to_ds_bypass_bus,
    output logic                       o_ms_load_pending
);

    // Position of mem_ren in the incoming bus; mem_wen sits just below it.
    localparam int unsigned MemRenBit = ES_TO_MS_BUS_WD - 2 - GPR_ADDR_WD - WORD_WD;

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    state_e                     state_q, state_d;
    logic                       ms_valid_q;
    logic [ES_TO_MS_BUS_WD-1:0] payload_q;
    logic [WORD_WD-1:0]         hold_q;

    logic                       gpr_wen;
    logic [GPR_ADDR_WD-1:0]     rd;
    logic [WORD_WD-1:0]         alu_result;
    logic                       mem_ren;
    logic                       mem_wen;
    logic [1:0]                 mem_size;
    logic                       mem_unsigned;
    logic [WORD_WD-1:0]         store_data;
    logic                       csr_wen;
    logic [CSR_ADDR_WD-1:0]     csr;
    logic [WORD_WD-1:0]         csr_result;

    assign {gpr_wen, rd, alu_result, mem_ren, mem_wen, mem_size, mem_unsigned, store_data,
            csr_wen, csr, csr_result} = payload_q;

    logic ms_ready_go;
    logic accept;
    logic es_is_mem;
    logic [5:0] sh;
    logic [WORD_WD-1:0] raw;
    logic [WORD_WD-1:0] ld_ext;
    logic [7:0] size_mask;
    logic [WORD_WD-1:0] gpr_final_result;

    assign ms_ready_go      = (state_q == StDone);
    assign o_ms_allowin     = !ms_valid_q || (ms_ready_go && i_ws_allowin);
    assign o_ms_to_ws_valid = ms_valid_q && ms_ready_go;
    assign accept           = i_es_to_ms_valid && o_ms_allowin;
    assign es_is_mem        = i_es_to_ms_bus[MemRenBit] | i_es_to_ms_bus[MemRenBit-1];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (accept) begin
                    state_d = es_is_mem ? StReq : StDone;
                end else if (o_ms_allowin) begin
                    state_d = StIdle;
                end
            end
            StReq:  if (i_dmem_req_ready) state_d = StWait;
            StWait: if (i_dmem_rsp_valid) state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= StIdle;
            ms_valid_q <= 1'b0;
            payload_q  <= '0;
            hold_q     <= '0;
        end else begin
            state_q <= state_d;
            if (o_ms_allowin) begin
                ms_valid_q <= i_es_to_ms_valid;
            end
            if (accept) begin
                payload_q <= i_es_to_ms_bus;
            end
            if (state_q == StWait && i_dmem_rsp_valid && mem_ren) begin
                hold_q <= ld_ext;
            end
        end
    end

    assign sh  = {alu_result[2:0], 3'b000};
    assign raw = i_dmem_rdata >> sh;

    always_comb begin
        ld_ext    = raw;
        size_mask = 8'hFF;
        unique case (mem_size)
            2'd0: begin
                ld_ext    = {{(WORD_WD-8){~mem_unsigned & raw[7]}}, raw[7:0]};
                size_mask = 8'h01;
            end
            2'd1: begin
                ld_ext    = {{(WORD_WD-16){~mem_unsigned & raw[15]}}, raw[15:0]};
                size_mask = 8'h03;
            end
            2'd2: begin
                ld_ext    = {{(WORD_WD-32){~mem_unsigned & raw[31]}}, raw[31:0]};
                size_mask = 8'h0F;
            end
            default: begin
                ld_ext    = raw;
                size_mask = 8'hFF;
            end
        endcase
    end

    assign o_dmem_req_valid = (state_q == StReq);
    assign o_dmem_addr      = alu_result;
    assign o_dmem_wen       = mem_wen;
    assign o_dmem_wdata     = store_data << sh;
    assign o_dmem_wmask     = mem_wen ? (size_mask << alu_result[2:0]) : 8'h00;

    assign gpr_final_result = mem_ren ? hold_q : alu_result;

    assign o_ms_to_ws_bus = {gpr_wen, rd, gpr_final_result, csr_wen, csr, csr_result};

    assign o_ms_to_ds_bypass_bus = {BYPASS_BUS_WD{ms_valid_q}} &
                                   {rd & {GPR_ADDR_WD{gpr_wen}},
                                    gpr_final_result & {WORD_WD{gpr_wen}},
                                    csr & {CSR_ADDR_WD{csr_wen}},
                                    csr_result & {WORD_WD{csr_wen}}};

    assign o_ms_load_pending = ms_valid_q && mem_ren && !ms_ready_go;

endmodule

// File: tb/tb_ysyx_22050710_mem_stage.sv
// Directed bench for ysyx_22050710_mem_stage: expected WB payloads are queued at issue and
// popped whenever the stage hands a result to WB.
module tb_ysyx_22050710_mem_stage;

    localparam int ES_W = 216;
    localparam int WS_W = 147;
    localparam int BP_W = 145;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            es_valid = 1'b0;
    logic [ES_W-1:0] es_bus = '0;
    logic            ms_allowin;
    logic            ws_allowin = 1'b1;
    logic            ws_valid;
    logic [WS_W-1:0] ws_bus;
    logic            req_valid;
    logic            req_ready = 1'b0;
    logic [63:0]     dmem_addr;
    logic            dmem_wen;
    logic [63:0]     dmem_wdata;
    logic [7:0]      dmem_wmask;
    logic            rsp_valid = 1'b0;
    logic [63:0]     rdata = '0;
    logic [BP_W-1:0] bypass;
    logic            load_pending;

    int n_assert = 0;
    int n_fail   = 0;
    logic [WS_W-1:0] exp_q[$];

    always #5 clk = ~clk;

    ysyx_22050710_mem_stage dut (
        .i_clk                 (clk),
        .i_rst                 (rst),
        .i_es_to_ms_valid      (es_valid),
        .i_es_to_ms_bus        (es_bus),
        .o_ms_allowin          (ms_allowin),
        .i_ws_allowin          (ws_allowin),
        .o_ms_to_ws_valid      (ws_valid),
        .o_ms_to_ws_bus        (ws_bus),
        .o_dmem_req_valid      (req_valid),
        .i_dmem_req_ready      (req_ready),
        .o_dmem_addr           (dmem_addr),
        .o_dmem_wen            (dmem_wen),
        .o_dmem_wdata          (dmem_wdata),
        .o_dmem_wmask          (dmem_wmask),
        .i_dmem_rsp_valid      (rsp_valid),
        .i_dmem_rdata          (rdata),
        .o_ms_to_ds_bypass_bus (bypass),
        .o_ms_load_pending     (load_pending)
    );

    function automatic logic [ES_W-1:0] make_es(
        input logic gw, input logic [4:0] rd, input logic [63:0] alu, input logic ren,
        input logic wen, input logic [1:0] size, input logic uns, input logic [63:0] sd,
        input logic cw, input logic [11:0] csr, input logic [63:0] cr);
        return {gw, rd, alu, ren, wen, size, uns, sd, cw, csr, cr};
    endfunction

    function automatic logic [WS_W-1:0] make_ws(
        input logic gw, input logic [4:0] rd, input logic [63:0] res,
        input logic cw, input logic [11:0] csr, input logic [63:0] cr);
        return {gw, rd, res, cw, csr, cr};
    endfunction

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Samples at the falling edge and retires any WB transfer against the scoreboard.
    task automatic sample();
        logic [WS_W-1:0] e;
        @(negedge clk);
        if (ws_valid && ws_allowin) begin
            n_assert++;
            assert (exp_q.size() > 0) else begin
                n_fail++;
                $error("FAIL sb_underflow: observed transfer %h, expected none", ws_bus);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_ws_bus", ws_bus, e);
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_op(input string tag, input logic [ES_W-1:0] es,
                          input logic [WS_W-1:0] exp, input logic [63:0] rd_data,
                          input logic is_load, input logic [7:0] exp_mask,
                          input logic [63:0] exp_wdata, input int ready_delay,
                          input int rsp_delay, input int stall);
        exp_q.push_back(exp);
        es_valid = 1'b1;
        es_bus   = es;
        sample();
        chk({tag, "_allowin"}, ms_allowin, 1'b1);
        advance();
        es_valid = 1'b0;
        es_bus   = ~es;
        // Responses during REQ must be ignored.
        for (int i = 0; i <= ready_delay; i++) begin
            req_ready = (i == ready_delay);
            rsp_valid = 1'b1;
            rdata     = ~rd_data;
            sample();
            chk({tag, "_req_valid"}, req_valid, 1'b1);
            chk({tag, "_addr"}, dmem_addr, es[209:146]);
            chk({tag, "_wen"}, dmem_wen, !is_load);
            chk({tag, "_wmask"}, dmem_wmask, exp_mask);
            chk({tag, "_wdata"}, dmem_wdata, exp_wdata);
            chk({tag, "_pend_req"}, load_pending, is_load);
            advance();
        end
        req_ready = 1'b0;
        for (int i = 0; i <= rsp_delay; i++) begin
            rsp_valid = (i == rsp_delay);
            rdata     = (i == rsp_delay) ? rd_data : ~rd_data;
            sample();
            chk({tag, "_req_low"}, req_valid, 1'b0);
            chk({tag, "_early_valid"}, ws_valid, 1'b0);
            chk({tag, "_pend_wait"}, load_pending, is_load);
            advance();
        end
        rsp_valid = 1'b0;
        rdata     = ~rd_data;
        for (int i = 0; i < stall; i++) begin
            ws_allowin = 1'b0;
            sample();
            chk({tag, "_stall_valid"}, ws_valid, 1'b1);
            chk({tag, "_stall_bus"}, ws_bus, exp);
            chk({tag, "_stall_allowin"}, ms_allowin, 1'b0);
            chk({tag, "_stall_pend"}, load_pending, 1'b0);
            advance();
        end
        ws_allowin = 1'b1;
        sample();
        chk({tag, "_done_valid"}, ws_valid, 1'b1);
        advance();
        sample();
        chk({tag, "_single_xfer"}, ws_valid, 1'b0);
        advance();
    endtask

    initial begin
        logic [ES_W-1:0] ops[3];
        logic [ES_W-1:0] es;

        #1 rst = 1'b1;
        #2;
        chk("rst_allowin", ms_allowin, 1'b1);
        chk("rst_ws_valid", ws_valid, 1'b0);
        chk("rst_req_valid", req_valid, 1'b0);
        chk("rst_bypass", bypass, '0);
        chk("rst_pending", load_pending, 1'b0);
        chk("rst_ws_bus", ws_bus, '0);
        advance();
        advance();
        rst = 1'b0;

        // Non-memory stream at full throughput.
        ops[0] = make_es(1, 5'd5, 64'h11, 0, 0, 2'd3, 0, 64'h0, 0, 12'h0, 64'h0);
        ops[1] = make_es(1, 5'd6, 64'h22, 0, 0, 2'd3, 0, 64'h0, 0, 12'h0, 64'h0);
        ops[2] = make_es(1, 5'd7, 64'h33, 0, 0, 2'd3, 0, 64'h0, 0, 12'h0, 64'h0);
        for (int k = 0; k < 4; k++) begin
            if (k < 3) begin
                es_valid = 1'b1;
                es_bus   = ops[k];
                exp_q.push_back(make_ws(1, 5'(k + 5), 64'(17 * (k + 1)), 0, 12'h0, 64'h0));
            end else begin
                es_valid = 1'b0;
            end
            sample();
            chk("alu_valid", ws_valid, k > 0);
            chk("alu_allowin", ms_allowin, 1'b1);
            advance();
        end
        sample();
        chk("alu_idle", ws_valid, 1'b0);
        advance();

        mem_op("lb", make_es(1, 5'd10, 64'h80000003, 1, 0, 2'd0, 0, 64'h0, 0, 12'h0, 64'h0),
               make_ws(1, 5'd10, 64'hFFFFFFFF_FFFFFF80, 0, 12'h0, 64'h0),
               64'h00000000_80FF0000, 1, 8'h00, 64'h0, 0, 0, 0);
        mem_op("lbu", make_es(1, 5'd11, 64'h80000003, 1, 0, 2'd0, 1, 64'h0, 0, 12'h0, 64'h0),
               make_ws(1, 5'd11, 64'h80, 0, 12'h0, 64'h0),
               64'h00000000_80FF0000, 1, 8'h00, 64'h0, 0, 0, 0);
        mem_op("lw", make_es(1, 5'd12, 64'h80000004, 1, 0, 2'd2, 0, 64'h0, 1, 12'h300,
                             64'h1234),
               make_ws(1, 5'd12, 64'hFFFFFFFF_89ABCDEF, 1, 12'h300, 64'h1234),
               64'h89ABCDEF_00000000, 1, 8'h00, 64'h0, 0, 0, 0);
        mem_op("sh", make_es(0, 5'd0, 64'h80000006, 0, 1, 2'd1, 0, 64'hBEEF, 0, 12'h0, 64'h0),
               make_ws(0, 5'd0, 64'h80000006, 0, 12'h0, 64'h0),
               64'h0, 0, 8'hC0, 64'hBEEF0000_00000000, 3, 0, 0);
        mem_op("ld_slow", make_es(1, 5'd13, 64'h80000008, 1, 0, 2'd3, 0, 64'h0, 0, 12'h0,
                                  64'h0),
               make_ws(1, 5'd13, 64'h01234567_89ABCDEF, 0, 12'h0, 64'h0),
               64'h01234567_89ABCDEF, 1, 8'h00, 64'h0, 0, 4, 2);

        // Reset while waiting for a response; the late response must be ignored.
        es = make_es(1, 5'd14, 64'h80000010, 1, 0, 2'd3, 0, 64'h0, 0, 12'h0, 64'h0);
        es_valid = 1'b1;
        es_bus   = es;
        sample();
        advance();
        es_valid  = 1'b0;
        req_ready = 1'b1;
        sample();
        chk("rstw_req", req_valid, 1'b1);
        advance();
        req_ready = 1'b0;
        sample();
        chk("rstw_pending", load_pending, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("rstw_allowin", ms_allowin, 1'b1);
        chk("rstw_ws_valid", ws_valid, 1'b0);
        chk("rstw_req_valid", req_valid, 1'b0);
        chk("rstw_bypass", bypass, '0);
        chk("rstw_pending0", load_pending, 1'b0);
        chk("rstw_ws_bus", ws_bus, '0);
        rsp_valid = 1'b1;
        rdata     = 64'hDEAD_BEEF_CAFE_F00D;
        advance();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("rstw_no_valid", ws_valid, 1'b0);
            chk("rstw_no_req", req_valid, 1'b0);
            advance();
            rsp_valid = 1'b0;
        end

        // Bypass content and masking.
        es_valid = 1'b1;
        es_bus   = make_es(1, 5'h0A, 64'h55, 0, 0, 2'd3, 0, 64'h0, 0, 12'h305, 64'hDEAD);
        exp_q.push_back(make_ws(1, 5'h0A, 64'h55, 0, 12'h305, 64'hDEAD));
        sample();
        chk("byp_idle", bypass, '0);
        advance();
        es_valid = 1'b0;
        sample();
        chk("byp_fields", bypass, {5'h0A, 64'h55, 12'h0, 64'h0});
        advance();
        sample();
        chk("byp_empty", bypass, '0);
        advance();

        chk("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
